demux8_deser: RTL and testbench

- Receive-side counterpart of the 8-to-1 select mux.
- Takes a serial bit stream, steers each accepted bit into position sel of an 8-bit assembly register, and advances sel with an internal 3-bit counter. This is a sequential 1-to-8 demux.
- Completed words go to an output holding register with a valid/ready handshake.
- Sits at the receive end of the mux-based serial link.

---
 rtl/demux8_deser.sv | 231 +++++++++++++++++++++++
 tb/tb_demux8_deser.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux8_deser.sv
// ============================================================================
// demux8_deser -- serial-to-parallel 1-to-DATA_W demux (receive side of the
// mux-based serial link).
//
// Each accepted serial bit is steered into position pos(sel) of an assembly
// register; sel advances with an internal SEL_W-bit counter. When the last
// position is written the completed word is moved into a holding register
// that is offered downstream with a valid/ready handshake.
//
// Parameters
//   SEL_W      select/counter width, DATA_W = 2**SEL_W
//   LSB_FIRST  1: first bit of a frame lands in dout[0]
//              0: first bit of a frame lands in dout[DATA_W-1]
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset
//   din         in   serial data bit
//   din_valid   in   din qualifies this cycle
//   din_sof     in   start of frame (only meaningful with din_valid)
//   dout        out  assembled word (holding register)
//   dout_valid  out  holding register full
//   dout_ready  in   consumer takes dout when dout_valid=1
//   sel         out  current write position counter (debug)
//   busy        out  FSM state: 1 = inside a frame (COLLECT)
//   overrun     out  one-cycle pulse when a completed frame is dropped
//
// Handshake: dout is transferred on any cycle where dout_valid=1 and
// dout_ready=1. While dout_valid=1 and dout_ready=0 dout is held stable.
// dout_ready is ignored while dout_valid=0. A completed frame may be loaded
// in the same cycle the previous word is taken, so back-to-back words with
// dout_ready held high have no bubbles.
//
// Build option
//   DEMUX8_MAJ5_VOTE_EN  when defined, each logical bit spans 5 din_valid
//                        samples and is resolved by majority vote
//                        (ones >= 3). When undefined, one sample per bit and
//                        no sample/ones counters exist.
// ============================================================================
module demux8_deser #(
    parameter int SEL_W     = 3,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din,
    input  logic                    din_valid,
    input  logic                    din_sof,
    output logic [(2**SEL_W)-1:0]   dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic [SEL_W-1:0]        sel,
    output logic                    busy,
    output logic                    overrun
);

    localparam int DATA_W = 2**SEL_W;

    localparam logic [SEL_W-1:0] SEL_ZERO = '0;
    localparam logic [SEL_W-1:0] SEL_MAX  = '1;
    localparam logic [SEL_W-1:0] SEL_ONE  = {{(SEL_W-1){1'b0}}, 1'b1};

    // FSM encoding; busy is the state register itself.
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [0:0]        state_r;
    logic [SEL_W-1:0]  sel_r;
    logic [DATA_W-1:0] asm_r;
    logic [DATA_W-1:0] dout_r;
    logic              dout_valid_r;
    logic              overrun_r;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    logic              bit_done;    // a logical bit is written this cycle
    logic              bit_val;     // value of that logical bit
    logic [SEL_W-1:0]  wr_sel;      // sequence index of the bit being written
    logic [SEL_W-1:0]  wr_pos;      // physical position in the word
    logic [DATA_W-1:0] asm_next;
    logic              frame_done;  // last position written this cycle
    logic              load;        // completed word moves to holding reg
    logic [SEL_W-1:0]  sel_next;
    logic [0:0]        state_next;

`ifdef DEMUX8_MAJ5_VOTE_EN
    // ------------------------------------------------------------------
    // Majority-of-5 sampling front end
    // ------------------------------------------------------------------
    logic [2:0] samp_cnt_r;   // samples already taken for the current bit
    logic [2:0] ones_cnt_r;   // ones among those samples
    logic [2:0] ones_total;   // ones including this cycle's sample
    logic [2:0] samp_cnt_next;
    logic [2:0] ones_cnt_next;

    always_comb begin
        ones_total = ones_cnt_r + {2'b00, din};

        // A sof sample never completes a bit: it becomes sample 0 of bit 0.
        bit_done = din_valid && !din_sof && (samp_cnt_r == 3'd4);
        bit_val  = (ones_total >= 3'd3);
        wr_sel   = sel_r;

        samp_cnt_next = samp_cnt_r;
        ones_cnt_next = ones_cnt_r;
        if (din_valid) begin
            if (din_sof) begin
                samp_cnt_next = 3'd1;
                ones_cnt_next = {2'b00, din};
            end else if (bit_done) begin
                samp_cnt_next = 3'd0;
                ones_cnt_next = 3'd0;
            end else begin
                samp_cnt_next = samp_cnt_r + 3'd1;
                ones_cnt_next = ones_total;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_cnt_r <= 3'd0;
            ones_cnt_r <= 3'd0;
        end else begin
            samp_cnt_r <= samp_cnt_next;
            ones_cnt_r <= ones_cnt_next;
        end
    end
`else
    // ------------------------------------------------------------------
    // One sample per bit: every accepted sample is a logical bit, and a
    // sof bit restarts the frame at index 0.
    // ------------------------------------------------------------------
    always_comb begin
        bit_done = din_valid;
        bit_val  = din;
        wr_sel   = din_sof ? SEL_ZERO : sel_r;
    end
`endif

    // ------------------------------------------------------------------
    // Position mapping, assembly update and frame completion
    // ------------------------------------------------------------------
    always_comb begin
        wr_pos = LSB_FIRST ? wr_sel : (SEL_MAX - wr_sel);

        // Only the addressed position changes; the rest keep old contents.
        asm_next = asm_r;
        if (bit_done) begin
            asm_next[wr_pos] = bit_val;
        end

        frame_done = bit_done && (wr_sel == SEL_MAX);

        // Holding register can take the new word if empty, or if its
        // current word is being taken this very cycle.
        load = frame_done && (!dout_valid_r || dout_ready);
    end

    // ------------------------------------------------------------------
    // Select counter and FSM
    // ------------------------------------------------------------------
    always_comb begin
        sel_next   = sel_r;
        state_next = state_r;
        if (din_valid) begin
`ifdef DEMUX8_MAJ5_VOTE_EN
            if (din_sof) begin
                sel_next = SEL_ZERO;
            end else if (bit_done) begin
                // Wraps to zero naturally after the last position.
                sel_next = sel_r + SEL_ONE;
            end
`else
            if (din_sof) begin
                sel_next = SEL_ONE;
            end else begin
                sel_next = sel_r + SEL_ONE;
            end
`endif
            case (state_r)
                ST_IDLE:    state_next = frame_done ? ST_IDLE : ST_COLLECT;
                ST_COLLECT: state_next = frame_done ? ST_IDLE : ST_COLLECT;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            sel_r   <= SEL_ZERO;
            asm_r   <= '0;
        end else begin
            state_r <= state_next;
            sel_r   <= sel_next;
            asm_r   <= asm_next;
        end
    end

    // ------------------------------------------------------------------
    // Output holding register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            if (load) begin
                dout_r       <= asm_next;
                dout_valid_r <= 1'b1;
            end else if (dout_valid_r && dout_ready) begin
                dout_valid_r <= 1'b0;
            end
            // Frame completed but holding register full and not drained.
            overrun_r <= frame_done && !load;
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign sel        = sel_r;
    assign busy       = (state_r == ST_COLLECT);
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_demux8_deser.sv
module tb_demux8_deser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic din_sof = 1'b0;
  logic dout_ready = 1'b0;

  logic [7:0] dout_l, dout_m;
  logic       dv_l, dv_m, busy_l, busy_m, ovr_l, ovr_m;
  logic [2:0] sel_l, sel_m;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs: both bit orders, same stimulus ----------------
  demux8_deser #(.SEL_W(3), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_sof(din_sof),
    .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
    .sel(sel_l), .busy(busy_l), .overrun(ovr_l));

  demux8_deser #(.SEL_W(3), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_sof(din_sof),
    .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
    .sel(sel_m), .busy(busy_m), .overrun(ovr_m));

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Bits of the current frame are kept in arrival order; a word is formed
  // only when eight have arrived.
  logic       bits_q[$];
  int         m_samp = 0;
  int         m_ones = 0;
  logic [7:0] m_dout_l = 8'h00;
  logic [7:0] m_dout_m = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ovr = 1'b0;

  always @(posedge clk) begin
    logic       complete;
    logic [7:0] wl, wm;
    complete = 1'b0;
    wl = 8'h00;
    wm = 8'h00;
    if (rst) begin
      bits_q.delete();
      m_samp = 0; m_ones = 0;
      m_dout_l = 8'h00; m_dout_m = 8'h00;
      m_valid = 1'b0; m_ovr = 1'b0;
    end else begin
      m_ovr = 1'b0;
      if (din_valid) begin
`ifdef DEMUX8_MAJ5_VOTE_EN
        if (din_sof) begin
          bits_q.delete();
          m_samp = 1;
          m_ones = int'(din);
        end else begin
          m_samp = m_samp + 1;
          m_ones = m_ones + int'(din);
          if (m_samp == 5) begin
            bits_q.push_back(m_ones >= 3);
            m_samp = 0;
            m_ones = 0;
          end
        end
`else
        if (din_sof) bits_q.delete();
        bits_q.push_back(din);
`endif
        if (bits_q.size() == 8) begin
          complete = 1'b1;
          for (int i = 0; i < 8; i++) begin
            wl[i]     = bits_q[i];
            wm[7 - i] = bits_q[i];
          end
          bits_q.delete();
        end
      end
      if (complete) begin
        if (!m_valid || dout_ready) begin
          m_dout_l = wl;
          m_dout_m = wm;
          m_valid  = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && dout_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- compare process (every cycle) ----------------
  always @(negedge clk) begin
    logic m_busy;
`ifdef DEMUX8_MAJ5_VOTE_EN
    m_busy = (bits_q.size() != 0) || (m_samp != 0);
`else
    m_busy = (bits_q.size() != 0);
`endif
    chk("lsb_dout",  dout_l, m_dout_l);
    chk("msb_dout",  dout_m, m_dout_m);
    chk("lsb_valid", {7'd0, dv_l}, {7'd0, m_valid});
    chk("msb_valid", {7'd0, dv_m}, {7'd0, m_valid});
    chk("lsb_sel",   {5'd0, sel_l}, 8'(bits_q.size()));
    chk("msb_sel",   {5'd0, sel_m}, 8'(bits_q.size()));
    chk("lsb_busy",  {7'd0, busy_l}, {7'd0, m_busy});
    chk("msb_busy",  {7'd0, busy_m}, {7'd0, m_busy});
    chk("lsb_ovr",   {7'd0, ovr_l}, {7'd0, m_ovr});
    chk("msb_ovr",   {7'd0, ovr_m}, {7'd0, m_ovr});
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic d, input logic s, input logic rdy);
    din_valid  = v;
    din        = d;
    din_sof    = s;
    dout_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // One logical bit; dout_ready is applied on the sample that completes it.
  task automatic send_bit(input logic b, input logic s, input logic rdy);
`ifdef DEMUX8_MAJ5_VOTE_EN
    for (int k = 0; k < 5; k++) step(1'b1, b, s && (k == 0), (k == 4) ? rdy : 1'b0);
`else
    step(1'b1, b, s, rdy);
`endif
  endtask

  // seq[i] is the i-th bit sent on the wire.
  task automatic send_seq(input logic [7:0] seq, input logic rdy);
    for (int i = 0; i < 8; i++) send_bit(seq[i], 1'b0, rdy);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b0);       // reset edge
    chk("rst_dout", dout_l, 8'h00);
    chk("rst_valid", {7'd0, dv_l}, 8'h00);
    chk("rst_sel", {5'd0, sel_l}, 8'h00);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Basic word: 1,0,0,0,1,1,0,1 with ready high.
    send_seq(8'b1011_0001, 1'b1);
    chk("basic_lsb", dout_l, 8'b1011_0001);
    chk("basic_msb", dout_m, 8'b1000_1101);
    chk("basic_model", m_dout_l, 8'hB1);
    chk("basic_valid", {7'd0, dv_l}, 8'h01);
    chk("basic_ovr", {7'd0, ovr_l}, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("basic_valid_drop", {7'd0, dv_l}, 8'h00);

    // Gaps: 0,0,1,1,0,1,0,1 with din_valid toggling; sel holds in gaps.
    begin
      logic [7:0] seq;
      seq = 8'b1010_1100;
      for (int i = 0; i < 8; i++) begin
        chk("gap_sel_pre", {5'd0, sel_m}, 8'(i));
        send_bit(seq[i], 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        if (i < 7) chk("gap_sel_hold", {5'd0, sel_m}, 8'(i + 1));
      end
    end
    chk("gap_msb", dout_m, 8'h35);
    chk("gap_lsb", dout_l, 8'hAC);
    step(1'b0, 1'b0, 1'b0, 1'b1);       // drain

    // Back-pressure: A5 held, 3C dropped with a single overrun pulse.
    send_seq(8'hA5, 1'b0);
    send_seq(8'h3C, 1'b0);
    chk("bp_ovr", {7'd0, ovr_l}, 8'h01);
    chk("bp_dout", dout_l, 8'hA5);
    chk("bp_valid", {7'd0, dv_l}, 8'h01);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_ovr_once", {7'd0, ovr_l}, 8'h00);
    chk("bp_valid_drop", {7'd0, dv_l}, 8'h00);

    // Accept and complete in the same cycle.
    send_seq(8'h0F, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'(8'hF0 >> i), 1'b0, 1'b0);
    chk("sim_hold", dout_l, 8'h0F);
    send_bit(1'b1, 1'b0, 1'b1);
    chk("sim_dout", dout_l, 8'hF0);
    chk("sim_valid", {7'd0, dv_l}, 8'h01);
    chk("sim_ovr", {7'd0, ovr_l}, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Resync: 3 bits abandoned, then sof + 3D.
    send_bit(1'b1, 1'b0, 1'b1);
    send_bit(1'b1, 1'b0, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    send_bit(1'b1, 1'b1, 1'b1);         // 3D bit 0 = 1, with sof
    for (int i = 1; i < 8; i++) send_bit(1'(8'h3D >> i), 1'b0, 1'b1);
    chk("sof_dout", dout_l, 8'h3D);
    chk("sof_ovr", {7'd0, ovr_l}, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset with a held word and a partial frame.
    send_seq(8'h5A, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
    chk("pre_rst_busy", {7'd0, busy_l}, 8'h01);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rst2_sel", {5'd0, sel_l}, 8'h00);
    chk("rst2_busy", {7'd0, busy_l}, 8'h00);
    chk("rst2_valid", {7'd0, dv_l}, 8'h00);
    chk("rst2_dout", dout_l, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef DEMUX8_MAJ5_VOTE_EN
    // Majority vote: {0,0,1,0,1}=0 and {1,1,0,1,0}=1 forming 8'h55.
    begin
      logic [4:0] g0, g1;
      g0 = 5'b10100;                    // samples 0,0,1,0,1 (index 0 first)
      g1 = 5'b01011;                    // samples 1,1,0,1,0
      for (int b = 0; b < 8; b++) begin
        for (int k = 0; k < 5; k++) begin
          step(1'b1, (b % 2 == 0) ? g1[k] : g0[k], 1'b0, 1'b1);
          if (b == 7 && k == 3) chk("vote_valid_39", {7'd0, dv_l}, 8'h00);
        end
      end
    end
    chk("vote_dout", dout_l, 8'h55);
    chk("vote_valid_40", {7'd0, dv_l}, 8'h01);
    step(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
